// File: rtl/jte_pkg.sv
// Shared constants and FIFO entry layout for the jump-target encoder.
package jte_pkg;

    localparam logic [5:0] OPC_J   = 6'd2;
    localparam logic [5:0] OPC_JAL = 6'd3;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_REGION   = 1;
    localparam int ERR_OPCODE   = 2;

    localparam int ERR_W   = 3;
    localparam int ENTRY_W = 32 + ERR_W;

    // Instruction in the upper bits, error flags in the lower bits.
    typedef struct packed {
        logic [31:0]      instr;
        logic [ERR_W-1:0] err;
    } jte_entry_t;

endpackage

// File: rtl/jte_fifo2.sv
// Two-entry synchronous FIFO with 1-bit wrapping pointers and a 0..2 occupancy count.
module jte_fifo2 #(
    parameter int W = 35
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         push_ok;
    logic         pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/jump_target_encoder.sv
// Encodes a jump target into a J-format word with validity flags, buffered in a 2-entry FIFO.
// Optional saturating error counter enabled by JUMP_TARGET_ENCODER_ERR_COUNT_EN.
module jump_target_encoder
    import jte_pkg::*;
#(
    parameter int OPC_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      target_i,
    input  logic [31:0]      pc_i,
    input  logic [OPC_W-1:0] opcode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      instr_o,
    output logic [2:0]       err_o,
    output logic [CNT_W-1:0] err_count_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready_o depends only on buffer occupancy, out_valid_o only on buffer non-empty.
    logic       accept;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] err_enc;
    jte_entry_t entry_in;
    jte_entry_t entry_out;
    logic       unused_pc;

    assign unused_pc = ^pc_i[27:0];

    always_comb begin
        err_enc               = '0;
        err_enc[ERR_MISALIGN] = (target_i[1:0] != 2'b00);
        err_enc[ERR_REGION]   = (target_i[31:28] != pc_i[31:28]);
        err_enc[ERR_OPCODE]   = (opcode_i != OPC_J) && (opcode_i != OPC_JAL);
    end

    // The field is emitted verbatim even when flags are raised.
    assign entry_in.instr = {opcode_i, target_i[27:2]};
    assign entry_in.err   = err_enc;

    assign in_ready_o = !fifo_full;
    assign accept     = in_valid_i && in_ready_o;

    jte_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (entry_in),
        .pop_i   (out_ready_i),
        .data_o  (entry_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid_o = !fifo_empty;
    assign instr_o     = entry_out.instr;
    assign err_o       = entry_out.err;

`ifdef JUMP_TARGET_ENCODER_ERR_COUNT_EN
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (accept && (err_enc != 3'b000) && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count_o = err_count_q;
`else
    assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_jump_target_encoder.sv
// Directed bench for jump_target_encoder: queue-based reference model plus literal checks.
module tb_jump_target_encoder;

`ifdef JUMP_TARGET_ENCODER_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] target_i;
    logic [31:0] pc_i;
    logic [5:0]  opcode_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] instr_o;
    logic [2:0]  err_o;
    logic [15:0] err_count_o;

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    logic [34:0] exp_q[$];
    logic [31:0] pop_log[$];
    int          exp_cnt = 0;

    jump_target_encoder #(
        .OPC_W (6),
        .CNT_W (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .target_i    (target_i),
        .pc_i        (pc_i),
        .opcode_i    (opcode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .instr_o     (instr_o),
        .err_o       (err_o),
        .err_count_o (err_count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference encode: J-format word from the field rules, flags from the validity rules.
    function automatic logic [34:0] encode(input logic [31:0] t, input logic [31:0] p,
                                           input logic [5:0] o);
        logic [31:0] word;
        logic [2:0]  e;
        word = (32'(o) << 26) | ((t & 32'h0FFF_FFFF) >> 2);
        e[0] = (t % 4) != 0;
        e[1] = (t / 32'h1000_0000) != (p / 32'h1000_0000);
        e[2] = !(o == 6'd2 || o == 6'd3);
        return {word, e};
    endfunction

    // Model update on the active edge using pre-edge inputs and occupancy.
    bit          do_push;
    logic [34:0] new_e;
    always @(posedge clk) begin
        if (rst_i) begin
            exp_q.delete();
            exp_cnt = 0;
        end else begin
            do_push = in_valid_i && (exp_q.size() < 2);
            if (out_ready_i && exp_q.size() > 0) begin
                pop_log.push_back(instr_o);
                void'(exp_q.pop_front());
            end
            if (do_push) begin
                new_e = encode(target_i, pc_i, opcode_i);
                exp_q.push_back(new_e);
                if (CNT_EN && new_e[2:0] != 3'b000 && exp_cnt < 65535) exp_cnt++;
            end
        end
    end

    // Scoreboard compare on the inactive edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready", {31'b0, in_ready_o}, {31'b0, exp_q.size() < 2});
            chk("out_valid", {31'b0, out_valid_o}, {31'b0, exp_q.size() > 0});
            chk("err_count", {16'b0, err_count_o}, exp_cnt);
            if (exp_q.size() > 0) begin
                chk("head_instr", instr_o, exp_q[0][34:3]);
                chk("head_err", {29'b0, err_o}, {29'b0, exp_q[0][2:0]});
            end
        end
    end

    // driver: called at a falling edge, returns at the falling edge after acceptance
    task automatic send(input logic [31:0] t, input logic [31:0] p, input logic [5:0] o);
        int n = 0;
        target_i   = t;
        pc_i       = p;
        opcode_i   = o;
        in_valid_i = 1'b1;
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready_o) begin
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept_within_20");
        end
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int n;
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        target_i    = '0;
        pc_i        = '0;
        opcode_i    = '0;
        out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", {29'b0, err_o}, 32'd0);
        chk("rst_err_count", {16'b0, err_count_o}, 32'd0);
        checking = 1'b1;

        send(32'h0040_0020, 32'h0040_0008, 6'd2);
        chk("basic_valid", {31'b0, out_valid_o}, 32'd1);
        chk("basic_instr", instr_o, 32'h0810_0008);
        chk("basic_err", {29'b0, err_o}, 32'd0);
        chk("basic_cnt", {16'b0, err_count_o}, 32'd0);

        send(32'h0040_0022, 32'h0040_0008, 6'd2);
        chk("misalign_instr", instr_o, 32'h0810_0008);
        chk("misalign_err", {29'b0, err_o}, 32'd1);
        chk("misalign_cnt", {16'b0, err_count_o}, CNT_EN ? 32'd1 : 32'd0);

        send(32'h2000_0000, 32'h1000_0000, 6'd3);
        chk("region_instr", instr_o, 32'h0C00_0000);
        chk("region_err", {29'b0, err_o}, 32'd2);

        send(32'h2000_0000, 32'h1000_0000, 6'd4);
        chk("opcode_instr", instr_o, 32'h1000_0000);
        chk("opcode_err", {29'b0, err_o}, 32'd6);
        chk("opcode_cnt", {16'b0, err_count_o}, CNT_EN ? 32'd3 : 32'd0);

        // back-to-back stream with the consumer always ready
        in_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            target_i = 32'h0040_0000 + 32'(i * 4) + ((i == 5) ? 32'd1 : 32'd0);
            pc_i     = (i == 6) ? 32'h3000_0000 : 32'h0040_0100;
            opcode_i = (i == 7) ? 6'd9 : 6'(2 + (i % 2));
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);

        // backpressure: A and B fill the buffer, C must wait
        out_ready_i = 1'b0;
        pop_log.delete();
        send(32'h0040_0100, 32'h0040_0000, 6'd2);
        send(32'h0040_0200, 32'h0040_0000, 6'd3);
        target_i   = 32'h0040_FFFC;
        pc_i       = 32'h0040_0000;
        opcode_i   = 6'd2;
        in_valid_i = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready_o}, 32'd0);
        chk("bp_head_held", instr_o, 32'h0810_0040);
        @(negedge clk);
        chk("bp_head_still", instr_o, 32'h0810_0040);
        out_ready_i = 1'b1;
        n = 0;
        while (!in_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_pop_count", pop_log.size(), 32'd3);
        if (pop_log.size() == 3) begin
            chk("bp_pop_a", pop_log[0], 32'h0810_0040);
            chk("bp_pop_b", pop_log[1], 32'h0C10_0080);
            chk("bp_pop_c", pop_log[2], 32'h0810_3FFF);
        end

        // reset with two entries buffered and a request pending
        out_ready_i = 1'b0;
        send(32'h0040_0004, 32'h0040_0000, 6'd2);
        send(32'h0040_0005, 32'h5040_0000, 6'd7);
        chk("mid_full_valid", {31'b0, out_valid_o}, 32'd1);
        rst_i      = 1'b1;
        in_valid_i = 1'b1;
        @(negedge clk);
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        chk("mid_rst_valid", {31'b0, out_valid_o}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready_o}, 32'd1);
        chk("mid_rst_cnt", {16'b0, err_count_o}, 32'd0);
        chk("mid_rst_instr", instr_o, 32'd0);
        out_ready_i = 1'b1;
        @(negedge clk);

`ifdef JUMP_TARGET_ENCODER_ERR_COUNT_EN
        target_i   = 32'h0040_0001;
        pc_i       = 32'h0040_0000;
        opcode_i   = 6'd2;
        in_valid_i = 1'b1;
        n = 0;
        while (exp_cnt < 32'hFFFE && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk("sat_pre", {16'b0, err_count_o}, 32'h0000_FFFE);
        repeat (3) @(negedge clk);
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat_hold", {16'b0, err_count_o}, 32'h0000_FFFF);
`else
        send(32'h0040_0001, 32'h0040_0000, 6'd2);
        send(32'h7040_0000, 32'h0040_0000, 6'd3);
        send(32'h0040_0000, 32'h0040_0000, 6'd0);
        @(negedge clk);
        chk("nocnt_zero", {16'b0, err_count_o}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jump_target_encoder.md
# jump_target_encoder

Inverse of the jump-address extender. Takes a 32-bit jump target and the PC it will be decoded against, and emits the J-format instruction word (`opcode`, `target[27:2]`). It flags targets that the extender can never reproduce: misaligned, out-of-region, or a non-jump opcode. The block sits on the instruction-generation path that feeds the instruction memory and cache-simulator traces, behind a valid/ready handshake with a 2-entry output buffer.

## Interface
- `OPC_W`, 6: opcode field width.
- `CNT_W`, 16: error-counter width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  request valid.
- `in_ready_o`  out  1  block can accept a request this cycle.
- `target_i`  in  32  byte address of the jump destination.
- `pc_i`  in  32  PC value that the extender will combine with the field (bits 31:28 used).
- `opcode_i`  in  `OPC_W`  2 = j, 3 = jal.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  consumer takes the head entry.
- `instr_o`  out  32  `{opcode_i, target_i[27:2]}`.
- `err_o`  out  3  bit0 misaligned (`target_i[1:0]` != 0); bit1 region mismatch (`target_i[31:28]` != `pc_i[31:28]`); bit2 illegal opcode (not 2 or 3).
- `err_count_o`  out  `CNT_W`  count of accepted requests with any `err_o` bit set; saturating.

## Operation
- Accept occurs when `in_valid_i && in_ready_o`. The encode is computed combinationally and written, together with its error bits, into the 2-entry FIFO.
- The instruction is always emitted, even when errors are flagged. The field is always `target_i[27:2]`, with no rounding or correction.
- Pop occurs when `out_valid_o && out_ready_i`. The head entry drives `instr_o` and `err_o`.
- `in_ready_o` = (occupancy < 2). It depends on occupancy only, not on `out_ready_i`. When the FIFO is full, no push is allowed even if a pop happens in the same cycle.
- When occupancy is 1 and push and pop occur in the same cycle, occupancy stays 1. The new entry becomes the head on the next cycle.
- Order is strict FIFO. Entries are never dropped or duplicated.
- FIFO pointers are 1 bit each and wrap modulo 2. Occupancy is 2 bits, range 0..2.
- The error counter increments by 1 on an accept with `err_o` != 0. It holds at all-ones and does not wrap.
- Round-trip invariant: when `err_o` == 0, `{pc_i[31:28], instr_o[25:0], 2'b00}` == `target_i`.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `instr_o`=0, `err_o`=0, `err_count_o`=0. FIFO occupancy is 0.
- Reset mid-operation discards all buffered entries on that edge. A request presented during reset is not accepted.
- Latency: an entry accepted at edge N is visible on `instr_o` with `out_valid_o`=1 after edge N (same-cycle visibility when the FIFO was empty). There is no combinational path from input to output.
- `err_count_o` reflects an accept one edge after it occurs.
- `instr_o` and `err_o` are held stable while `out_valid_o`=1 and `out_ready_i`=0.
- Throughput: 1 request per cycle while the consumer pops every cycle.

## Configuration
- Macro: `JUMP_TARGET_ENCODER_ERR_COUNT_EN`.
- When defined, the error counter is implemented as described above.
- When undefined, the counter register is not generated and `err_count_o` is tied to 0. `err_o` and all other behaviour are unchanged.

## Structure
- Shared package `jte_pkg` holds:
  - opcode constants `OPC_J`=6'd2 and `OPC_JAL`=6'd3;
  - error bit indices `ERR_MISALIGN`=0, `ERR_REGION`=1, `ERR_OPCODE`=2;
  - the FIFO entry width (35 = 32 + 3).
- Sub-module `jte_fifo2` is a parameterised 2-entry synchronous FIFO with data width, push/pop, full/empty and sync reset. Encode and error logic stay in the top level.

## Test plan
- Basic j: `pc_i`=0x00400008, `target_i`=0x00400020, `opcode_i`=2, `out_ready_i`=1 -> `instr_o`=0x08100008, `err_o`=0, `err_count_o`=0.
- Misaligned: `pc_i`=0x00400008, `target_i`=0x00400022, `opcode_i`=2 -> `instr_o`=0x08100008, `err_o`=3'b001, `err_count_o`=1.
- Region plus jal: `pc_i`=0x10000000, `target_i`=0x20000000, `opcode_i`=3 -> `instr_o`=0x0C000000, `err_o`=3'b010. Repeat with `opcode_i`=4 -> `err_o`=3'b110.
- Backpressure: hold `out_ready_i`=0 and offer 3 requests A, B, C -> `in_ready_o` drops after B and C waits. Then raise `out_ready_i` -> outputs A, B, C in order with no loss.
- Reset mid-stream: 2 entries buffered, assert `rst_i` for 1 cycle -> `out_valid_o`=0, `in_ready_o`=1, `err_count_o`=0 on the next cycle.
- Saturation (with the macro defined): force the counter to 0xFFFE and send 3 erroneous requests -> `err_count_o` reads 0xFFFF and holds. With the macro undefined -> `err_count_o` stays 0.
